// File: rtl/fwd_operand_sel.sv
// fwd_operand_sel: operand source selection and load-use stall detection for an
// in-order RV32I pipeline. A short tag pipeline records which destination
// register each in-flight result stage will write. Decode-stage source
// registers are matched against it so the youngest producer forwards its
// result. The selects, the operands and the stall are combinational from the
// current inputs and the tag state. The tag state is the only storage.
module fwd_operand_sel #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 3,
    parameter int SELW      = $clog2(DEPTH + 2)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_issue_valid,
    input  logic                       i_hold,
    input  logic [31:0]                i_if_instr,
    input  logic [DATAWIDTH-1:0]       i_pc,
    input  logic [DATAWIDTH-1:0]       i_rf_rs1_data,
    input  logic [DATAWIDTH-1:0]       i_rf_rs2_data,
    input  logic [DEPTH*DATAWIDTH-1:0] i_stage_data,
    output logic [DATAWIDTH-1:0]       o_opA,
    output logic [DATAWIDTH-1:0]       o_opB,
    output logic [SELW-1:0]            o_selA,
    output logic [SELW-1:0]            o_selB,
    output logic                       o_stall
);

    // RV32I major opcodes that matter for forwarding
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Select codes: 0 register file, k+1 result stage k, DEPTH+1 the PC
    localparam logic [SELW-1:0] SEL_RF = SELW'(0);
    localparam logic [SELW-1:0] SEL_PC = SELW'(DEPTH + 1);

    // Opcode classes that produce a register result
    function automatic logic writes_rd(input logic [6:0] op);
        logic w;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_OP, OP_OPIMM, OP_LOAD: w = 1'b1;
            default:                  w = 1'b0;
        endcase
        return w;
    endfunction

    // Everything except the upper-immediate and JAL forms consumes rs1
    function automatic logic reads_rs1(input logic [6:0] op);
        logic r;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL: r = 1'b0;
            default:                  r = 1'b1;
        endcase
        return r;
    endfunction

    // Only register-register ALU, store and branch consume rs2
    function automatic logic reads_rs2(input logic [6:0] op);
        logic r;
        case (op)
            OP_OP, OP_STORE, OP_BRANCH: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

    // Priority encoder: lowest matching stage (youngest producer) wins, 0 if none
    function automatic logic [SELW-1:0] youngest_code(input logic [DEPTH-1:0] m);
        logic [SELW-1:0] code;
        code = SEL_RF;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (m[k]) begin
                code = SELW'(k + 1);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    // Operand data multiplexer driven by a select code
    function automatic logic [DATAWIDTH-1:0] pick_operand(
        input logic [SELW-1:0]            sel,
        input logic [DATAWIDTH-1:0]       rf,
        input logic [DATAWIDTH-1:0]       pc,
        input logic [DEPTH*DATAWIDTH-1:0] stage
    );
        logic [DATAWIDTH-1:0] d;
        d = rf;
        if (sel == SEL_PC) begin
            d = pc;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (sel == SELW'(k + 1)) begin
                    d = stage[k*DATAWIDTH +: DATAWIDTH];
                end else begin
                    d = d;
                end
            end
        end
        return d;
    endfunction

    // Tag pipeline state; entry k describes the result on stage slice k
    logic [DEPTH-1:0] valid_r;
    logic [4:0]       rd_r [DEPTH];
    logic [DEPTH-1:0] load_r;

    // Decode-stage fields
    logic [6:0]       opcode_s;
    logic [4:0]       rd_s;
    logic [4:0]       rs1_s;
    logic [4:0]       rs2_s;
    logic             use_rs1_s;
    logic             use_rs2_s;
    logic             is_pc_rel_s;
    logic [DEPTH-1:0] match_a_s;
    logic [DEPTH-1:0] match_b_s;
    logic [SELW-1:0]  fwd_a_s;
    logic [SELW-1:0]  fwd_b_s;
    logic [SELW-1:0]  sel_a_s;
    logic [SELW-1:0]  sel_b_s;
    logic             stall_s;
    logic             enter_valid_s;
    logic             unused_bits_s;

    assign opcode_s = i_if_instr[6:0];
    assign rd_s     = i_if_instr[11:7];
    assign rs1_s    = i_if_instr[19:15];
    assign rs2_s    = i_if_instr[24:20];

    // Funct/immediate bits and the oldest load flag never steer forwarding
    assign unused_bits_s = &{1'b0, i_if_instr[31:25], i_if_instr[14:12], load_r};

    // Decode which sources are consumed; x0 is excluded here as a second guard
    always_comb begin
        use_rs1_s   = reads_rs1(opcode_s) && (rs1_s != 5'd0);
        use_rs2_s   = reads_rs2(opcode_s) && (rs2_s != 5'd0);
        is_pc_rel_s = (opcode_s == OP_AUIPC) || (opcode_s == OP_JAL);
    end

    // Compare each consumed source against every valid in-flight destination
    always_comb begin
        match_a_s = {DEPTH{1'b0}};
        match_b_s = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            match_a_s[k] = use_rs1_s && valid_r[k] && (rd_r[k] == rs1_s);
            match_b_s[k] = use_rs2_s && valid_r[k] && (rd_r[k] == rs2_s);
        end
    end

    // Resolve select codes; PC-relative forms take the PC on operand A
    always_comb begin
        fwd_a_s = youngest_code(match_a_s);
        fwd_b_s = youngest_code(match_b_s);
        if (is_pc_rel_s) begin
            sel_a_s = SEL_PC;
        end else begin
            sel_a_s = fwd_a_s;
        end
        sel_b_s = fwd_b_s;
    end

    // Load-use hazard: youngest producer of a consumed source is a load still in stage 0
    always_comb begin
        stall_s = i_issue_valid && load_r[0] &&
                  ((fwd_a_s == SELW'(1)) || (fwd_b_s == SELW'(1)));
    end

    // Decide whether the decode-stage instruction enters the tag pipeline as a producer
    always_comb begin
        enter_valid_s = i_issue_valid && !stall_s &&
                        writes_rd(opcode_s) && (rd_s != 5'd0);
    end

    // Tag pipeline: async clear, freeze on hold, otherwise age one stage per cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_r <= {DEPTH{1'b0}};
            load_r  <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                rd_r[k] <= 5'd0;
            end
        end else if (i_hold) begin
            valid_r <= valid_r;
            load_r  <= load_r;
            for (int k = 0; k < DEPTH; k++) begin
                rd_r[k] <= rd_r[k];
            end
        end else begin
            valid_r[0] <= enter_valid_s;
            rd_r[0]    <= rd_s;
            load_r[0]  <= (opcode_s == OP_LOAD);
            for (int k = 1; k < DEPTH; k++) begin
                valid_r[k] <= valid_r[k-1];
                rd_r[k]    <= rd_r[k-1];
                load_r[k]  <= load_r[k-1];
            end
        end
    end

    // Drive outputs straight from the resolved selects
    always_comb begin
        o_selA  = sel_a_s;
        o_selB  = sel_b_s;
        o_opA   = pick_operand(sel_a_s, i_rf_rs1_data, i_pc, i_stage_data);
        o_opB   = pick_operand(sel_b_s, i_rf_rs2_data, i_pc, i_stage_data);
        o_stall = stall_s;
    end

endmodule
